// File: rtl/alien_sprite_reader_pkg.sv
// Purpose : shared sizes, colour key and reader FSM encoding for the alien sprite reader.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package alien_sprite_reader_pkg;

  localparam int         DEF_SPR_W    = 31;     // sprite width in pixels
  localparam int         DEF_SPR_H    = 26;     // sprite height in lines
  localparam int         DEF_ADDR_W   = 10;     // ROM address width
  localparam int         DEF_H_ACTIVE = 640;    // visible pixels per line
  localparam int         DEF_V_ACTIVE = 480;    // visible lines per frame
  localparam logic [7:0] DEF_TRANSP   = 8'h00;  // colour treated as see-through

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for the first sprite line of the frame
    ST_SCAN = 2'd1,  // between sprite lines, waiting for the lead-in column
    ST_DRAW = 2'd2,  // issuing one ROM address per pixel
    ST_DONE = 2'd3   // sprite finished, quiet until the next frame
  } state_t;

endpackage

// File: rtl/alien_sprite_reader.sv
// Purpose : raster-order read side of the alien sprite ROM, aligned to the VGA beam.
// Latency : ROM address leads the beam by 1 pixel; pixel outputs line up with sx (0 column offset).
// Backpressure: none, free-running at pixel rate; frame_start overrides everything.
//
// Ports:
//   clk_pix, reset_n       pixel clock, async active-low reset
//   frame_start            1-cycle pulse at the top-left of each frame; latches pos_x/pos_y
//   sx, sy                 current beam column/line
//   pos_x, pos_y           requested sprite top-left, sampled on frame_start only
//   rom_dout               ROM data for the address presented in the previous cycle
//   rom_addr               registered ROM address
//   pix_color/spr_hit/pix_valid  pixel colour, in-box flag, opaque-pixel flag
module alien_sprite_reader
  import alien_sprite_reader_pkg::*;
#(
  parameter int         SPR_W    = DEF_SPR_W,
  parameter int         SPR_H    = DEF_SPR_H,
  parameter int         ADDR_W   = DEF_ADDR_W,
  parameter int         H_ACTIVE = DEF_H_ACTIVE,
  parameter int         V_ACTIVE = DEF_V_ACTIVE,
  parameter logic [7:0] TRANSP   = DEF_TRANSP
) (
  input  logic              clk_pix,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [7:0]        rom_dout,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        pix_color,
  output logic              spr_hit,
  output logic              pix_valid
);

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  // The box must start at column 2 or later so the 2-pixel lead-in column exists.
  localparam logic [9:0]        POS_X_MIN = 10'd2;
  localparam logic [9:0]        POS_X_MAX = 10'(H_ACTIVE - SPR_W);
  localparam logic [9:0]        POS_Y_MAX = 10'(V_ACTIVE - SPR_H);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SPR_W);

  state_t              r_state,     w_state_nxt;
  logic [9:0]          r_pos_x,     w_pos_x_clamp;
  logic [9:0]          r_pos_y,     w_pos_y_clamp;
  logic [ROW_W-1:0]    r_row_cnt,   w_row_nxt;
  logic [COL_W-1:0]    r_col_cnt,   w_col_nxt;
  logic [ADDR_W-1:0]   r_line_base, w_base_nxt;
  logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
  logic                r_hit,       w_hit_nxt;
  logic                w_lead_in;

  // Two columns before the box: this cycle decides, the next cycle presents
  // address col 0, and the ROM answers in the cycle the beam reaches the box.
  assign w_lead_in = (sx == (r_pos_x - POS_X_MIN));

  always_comb begin
    w_pos_x_clamp = pos_x;
    if (pos_x < POS_X_MIN)      w_pos_x_clamp = POS_X_MIN;
    else if (pos_x > POS_X_MAX) w_pos_x_clamp = POS_X_MAX;
    w_pos_y_clamp = (pos_y > POS_Y_MAX) ? POS_Y_MAX : pos_y;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_cnt;
    w_col_nxt   = r_col_cnt;
    w_base_nxt  = r_line_base;
    w_addr_nxt  = r_addr;
    w_hit_nxt   = 1'b0;
    if (frame_start) begin
      w_state_nxt = ST_IDLE;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
      w_base_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((sy == r_pos_y) && w_lead_in) begin
            w_state_nxt = ST_DRAW;
            w_addr_nxt  = r_line_base;
          end
        end
        // Lead-in column occurs once per line, so this picks up the next line.
        ST_SCAN: begin
          if (w_lead_in) begin
            w_state_nxt = ST_DRAW;
            w_addr_nxt  = r_line_base;
          end
        end
        ST_DRAW: begin
          w_hit_nxt = 1'b1;
          if (r_col_cnt == COL_LAST) begin
            // Address holds at the line's last pixel until the next line starts.
            w_col_nxt  = '0;
            w_base_nxt = r_line_base + LINE_STEP;
            if (r_row_cnt == ROW_LAST) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_row_nxt   = r_row_cnt + ROW_W'(1);
              w_state_nxt = ST_SCAN;
            end
          end else begin
            w_col_nxt  = r_col_cnt + COL_W'(1);
            w_addr_nxt = r_line_base + ADDR_W'(r_col_cnt) + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pos_x     <= POS_X_MIN;
      r_pos_y     <= '0;
      r_row_cnt   <= '0;
      r_col_cnt   <= '0;
      r_line_base <= '0;
      r_addr      <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_cnt   <= w_row_nxt;
      r_col_cnt   <= w_col_nxt;
      r_line_base <= w_base_nxt;
      r_addr      <= w_addr_nxt;
      r_hit       <= w_hit_nxt;
      if (frame_start) begin
        r_pos_x <= w_pos_x_clamp;
        r_pos_y <= w_pos_y_clamp;
      end
    end
  end

  assign rom_addr  = r_addr;
  assign spr_hit   = r_hit;
  assign pix_color = r_hit ? rom_dout : 8'h00;
  assign pix_valid = r_hit && (rom_dout != TRANSP);

endmodule

// File: tb/tb_alien_sprite_reader.sv
// Purpose : scoreboard bench for alien_sprite_reader against a raster-rule pixel model.
// Latency : expects each sprite pixel in the same cycle the beam crosses its column.
// Backpressure: none; beam is a compressed window around the sprite box each frame.
module tb_alien_sprite_reader;

  localparam int W  = 31;
  localparam int H  = 26;
  localparam int HA = 640;
  localparam int VA = 480;

  logic       clk_pix = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] sx = '0, sy = '0, pos_x = '0, pos_y = '0;
  logic [7:0] rom_dout = 8'h00;
  logic [9:0] rom_addr;
  logic [7:0] pix_color;
  logic       spr_hit;
  logic       pix_valid;

  alien_sprite_reader dut (
    .clk_pix    (clk_pix),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .sx         (sx),
    .sy         (sy),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .rom_dout   (rom_dout),
    .rom_addr   (rom_addr),
    .pix_color  (pix_color),
    .spr_hit    (spr_hit),
    .pix_valid  (pix_valid)
  );

  always #5 clk_pix = ~clk_pix;

  // Registered ROM model: data for an address appears one cycle later.
  logic [7:0] rom_mem [0:1023];
  always @(posedge clk_pix) rom_dout <= rom_mem[rom_addr];

  typedef struct {
    int         cyc;
    logic [7:0] col;
    logic       vld;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   hit_cnt = 0;
  int   cur_px = 2;
  int   cur_py = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per spr_hit cycle.
  always @(negedge clk_pix) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_hit: no spr_hit at cycle %0d, expected one", sb[0].cyc);
      void'(sb.pop_front());
    end
    if (spr_hit) begin
      hit_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit: spr_hit=1 at cycle %0d sx=%0d sy=%0d, expected 0", cyc, sx, sy);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hit_cycle", cyc, e.cyc);
        check("pix_color", pix_color, e.col);
        check("pix_valid", pix_valid, e.vld);
      end
    end else begin
      check("idle_color", pix_color, 0);
      check("idle_valid", pix_valid, 0);
    end
  end

  task automatic drive(input int x, input int y, input logic fs);
    @(posedge clk_pix);
    #1;
    cyc++;
    sx = 10'(x);
    sy = 10'(y);
    frame_start = fs;
  endtask

  function automatic int clamp_x(input int p);
    if (p < 2) return 2;
    if (p > HA - W) return HA - W;
    return p;
  endfunction

  function automatic int clamp_y(input int p);
    return (p > VA - H) ? VA - H : p;
  endfunction

  task automatic fs_cycle(input int nx, input int ny);
    drive(0, 0, 1'b1);
    pos_x  = 10'(nx);
    pos_y  = 10'(ny);
    cur_px = clamp_x(nx);
    cur_py = clamp_y(ny);
  endtask

  task automatic push_pix(input int r, input int c);
    exp_t e;
    e.cyc = cyc + 1;
    e.col = rom_mem[r * W + c];
    e.vld = (rom_mem[r * W + c] != 8'h00);
    sb.push_back(e);
  endtask

  // kind 0: full frame; 1: frame_start at (a_row,a_col) relatching (a_px,a_py);
  // 2: reset at (a_row,a_col). mid_px>=0 changes pos_x mid-frame without frame_start.
  task automatic do_frame(input int kind, input int a_row, input int a_col,
                          input int a_px, input int a_py, input int mid_px);
    int  x0, x1, y0, y1, base_hits, exp_hits, px, py;
    bit  stop;
    stop      = 1'b0;
    base_hits = hit_cnt;
    exp_hits  = 0;
    px = cur_px;
    py = cur_py;
    y0 = (py > 0) ? py - 1 : 0;
    y1 = (py + H > VA - 1) ? VA - 1 : py + H;
    x0 = (px >= 4) ? px - 4 : 0;
    x1 = (px + W + 3 > HA - 1) ? HA - 1 : px + W + 3;
    for (int y = y0; y <= y1 && !stop; y++) begin
      for (int x = x0; x <= x1 && !stop; x++) begin
        int r, c;
        r = y - py;
        c = x - px;
        if (kind != 0 && r == a_row && c == a_col) begin
          stop = 1'b1;
          if (kind == 1) begin
            push_pix(r, c);
            exp_hits++;
            fs_cycle(a_px, a_py);
          end else begin
            drive(x, y, 1'b0);
            #2 reset_n = 1'b0;
            #1;
            check("rst_addr", rom_addr, 0);
            check("rst_hit", spr_hit, 0);
            check("rst_valid", pix_valid, 0);
            check("rst_color", pix_color, 0);
            sb.delete();
            drive(x, y, 1'b0);
            drive(x, y, 1'b0);
            reset_n = 1'b1;
            base_hits = hit_cnt;
            for (int yy = py; yy < py + 3; yy++)
              for (int xx = x0; xx <= x1; xx++) begin
                drive(xx, yy, 1'b0);
                check("post_reset_addr", rom_addr, 0);
              end
          end
        end else begin
          if (r >= 0 && r < H && c >= 0 && c < W) begin
            push_pix(r, c);
            exp_hits++;
          end
          drive(x, y, 1'b0);
          // Beam at box column c-1 must present the address of column c.
          if (r >= 0 && r < H && c >= -1 && c < W - 1)
            check("rom_addr", rom_addr, r * W + c + 1);
          if (mid_px >= 0 && r == 5 && c == 0) pos_x = 10'(mid_px);
        end
      end
    end
    @(negedge clk_pix);
    #1;
    check("frame_queue_empty", sb.size(), 0);
    if (kind == 0) begin
      check("frame_hits", hit_cnt - base_hits, W * H);
      check("done_addr", rom_addr, W * H - 1);
    end else if (kind == 1) begin
      check("abort_hits", hit_cnt - base_hits, exp_hits);
    end else begin
      check("post_reset_hits", hit_cnt - base_hits, 0);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 1024; i++) rom_mem[i] = (i == 5) ? 8'h00 : 8'h3C;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_pattern();
    #2 reset_n = 1'b0;
    #1;
    check("reset_addr", rom_addr, 0);
    check("reset_hit", spr_hit, 0);
    check("reset_valid", pix_valid, 0);
    drive(0, 0, 1'b0);
    drive(0, 0, 1'b0);
    reset_n = 1'b1;

    // Nominal frame with a single transparent pixel at address 5.
    fs_cycle(100, 50);
    do_frame(0, 0, 0, 0, 0, -1);

    fill_random();
    // Clamping: left edge, right edge and bottom edge.
    fs_cycle(0, 30);
    do_frame(0, 0, 0, 0, 0, -1);
    fs_cycle(700, 470);
    do_frame(0, 0, 0, 0, 0, -1);

    // Position changes between frame_start pulses are ignored.
    fs_cycle(100, 50);
    do_frame(0, 0, 0, 0, 0, 300);
    fs_cycle(300, 50);
    do_frame(0, 0, 0, 0, 0, -1);

    // Abort mid-sprite, then the relatched frame draws from address 0.
    fs_cycle(150, 40);
    do_frame(1, 10, 15, 200, 10, -1);
    do_frame(0, 0, 0, 0, 0, -1);

    // Randomised positions and content.
    for (int i = 0; i < 4; i++) begin
      fill_random();
      fs_cycle(int'($urandom_range(0, 700)), int'($urandom_range(1, 500)));
      do_frame(0, 0, 0, 0, 0, -1);
    end

    // Async reset mid-DRAW, then silence with no frame_start.
    fs_cycle(100, 50);
    do_frame(2, 3, 7, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
